// File: rtl/cpu_pkg.sv
// Shared CPU definitions: fetch FSM encodings, instruction field positions,
// next-PC select values and the op_code set shared with control_unit.
package cpu_pkg;

  typedef enum logic [2:0] {
    FETCH_IDLE = 3'b001,
    FETCH_REQ  = 3'b010,
    FETCH_WAIT = 3'b100
  } fetch_state_t;

  localparam int OP_HI  = 31;
  localparam int OP_LO  = 26;
  localparam int RS_HI  = 25;
  localparam int RS_LO  = 21;
  localparam int RT_HI  = 20;
  localparam int RT_LO  = 16;
  localparam int RD_HI  = 15;
  localparam int RD_LO  = 11;
  localparam int IMM_HI = 15;
  localparam int TGT_HI = 25;

  localparam logic [31:0] NOP_WORD = 32'h0000_0000;

  localparam logic NPC_SEQ    = 1'b0;
  localparam logic NPC_BRANCH = 1'b1;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_XORI  = 6'b001110;

endpackage

// File: rtl/instruction_fetch_unit_pc_register.sv
// Program counter: PC flop, +4 incrementer and next-PC select with
// branch targets forced to word alignment.
module pc_register
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        update_en,
  input  logic        mux_c,
  input  logic [31:0] branch_target,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic [31:0] next_pc
);

  logic [31:0] pc_reg;
  logic [31:0] target_aligned;

  assign pc             = pc_reg;
  assign pc_plus4       = pc_reg + 32'd4;
  assign target_aligned = branch_target & ~32'h0000_0003;

  always_comb begin
    next_pc = pc_reg;
    if (update_en) begin
      next_pc = (mux_c == NPC_BRANCH) ? target_aligned : pc_plus4;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_reg <= RESET_PC;
    end else begin
      pc_reg <= next_pc;
    end
  end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch: PC, IR and the IDLE/REQ/WAIT memory handshake FSM.
// Optional FETCH_TIMEOUT_EN adds a bounded wait that returns a NOP and a sticky error.
module instruction_fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC       = 32'h0000_0000,
  parameter int          TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        instruction_memory_read,
  input  logic        pc_update,
  input  logic        mux_c,
  input  logic [31:0] branch_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic        ir_valid,
  output logic        fetch_busy,
  output logic        fetch_error,
  output logic [5:0]  op_code,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [4:0]  rd,
  output logic [15:0] imm16,
  output logic [25:0] target26,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4
);

  fetch_state_t state_reg, state_next;
  logic [31:0]  ir_reg;
  logic [31:0]  addr_reg;
  logic         ir_valid_reg;
  logic [31:0]  next_pc;
  logic         idle, busy, fetch_start, data_done, timeout;

  assign idle        = (state_reg == FETCH_IDLE);
  assign busy        = !idle;
  assign fetch_start = idle && instruction_memory_read;
  assign data_done   = busy && imem_ready;

  // The PC only moves between instructions, so updates are gated to IDLE.
  pc_register #(
    .RESET_PC(RESET_PC)
  ) u_pc (
    .clk          (clk),
    .rst          (rst),
    .update_en    (idle && pc_update),
    .mux_c        (mux_c),
    .branch_target(branch_target),
    .pc           (pc),
    .pc_plus4     (pc_plus4),
    .next_pc      (next_pc)
  );

`ifdef FETCH_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_reg;
  logic             error_reg;

  // A ready on the final cycle takes priority over the timeout.
  assign timeout     = busy && !imem_ready && (cnt_reg == CNT_LAST);
  assign fetch_error = error_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_reg   <= '0;
      error_reg <= 1'b0;
    end else begin
      if (fetch_start) begin
        cnt_reg <= '0;
      end else if (busy) begin
        cnt_reg <= cnt_reg + 1'b1;
      end
      if (timeout) begin
        error_reg <= 1'b1;
      end
    end
  end
`else
  assign timeout     = 1'b0;
  assign fetch_error = (TIMEOUT_CYCLES < 0);
`endif

  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      FETCH_IDLE: if (instruction_memory_read) state_next = FETCH_REQ;
      FETCH_REQ:  state_next = (imem_ready || timeout) ? FETCH_IDLE : FETCH_WAIT;
      FETCH_WAIT: if (imem_ready || timeout) state_next = FETCH_IDLE;
      default:    state_next = FETCH_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= FETCH_IDLE;
      ir_reg       <= NOP_WORD;
      ir_valid_reg <= 1'b0;
      addr_reg     <= RESET_PC;
    end else begin
      state_reg <= state_next;
      if (fetch_start) begin
        addr_reg     <= next_pc;
        ir_valid_reg <= 1'b0;
      end
      if (data_done) begin
        ir_reg       <= imem_rdata;
        ir_valid_reg <= 1'b1;
      end else if (timeout) begin
        ir_reg       <= NOP_WORD;
        ir_valid_reg <= 1'b1;
      end
    end
  end

  assign imem_req   = busy;
  assign fetch_busy = busy;
  assign imem_addr  = addr_reg;
  assign ir_valid   = ir_valid_reg;
  assign op_code    = ir_reg[OP_HI:OP_LO];
  assign rs         = ir_reg[RS_HI:RS_LO];
  assign rt         = ir_reg[RT_HI:RT_LO];
  assign rd         = ir_reg[RD_HI:RD_LO];
  assign imm16      = ir_reg[IMM_HI:0];
  assign target26   = ir_reg[TGT_HI:0];

endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
- Upstream neighbour of the 5-state multi-cycle control_unit.
- Holds the PC and the instruction register (IR).
- Fetches a word from instruction memory over a req/ready handshake when the control unit pulses instruction_memory_read.
- Splits the IR into the op_code and operand fields, and updates the PC from the control unit's mux_c select at the end of each instruction.

Parameters:
- RESET_PC, 32'h0000_0000, PC value after reset.
- TIMEOUT_CYCLES, 16, max wait for imem_ready. Used only with FETCH_TIMEOUT_EN.

Ports:
- clk  in  1  system clock, rising-edge.
- rst  in  1  asynchronous, active-high reset.
- instruction_memory_read  in  1  fetch start strobe from control_unit.
- pc_update  in  1  one-cycle strobe: commit next PC (writeback slot).
- mux_c  in  1  next-PC select: 0 = PC+4, 1 = branch_target.
- branch_target  in  32  target address from the execute datapath.
- imem_req  out  1  request to instruction memory.
- imem_addr  out  32  word address presented with imem_req.
- imem_ready  in  1  memory has imem_rdata valid this cycle.
- imem_rdata  in  32  instruction word.
- ir_valid  out  1  IR holds a completed fetch.
- fetch_busy  out  1  high in REQ/WAIT; control_unit stalls on it.
- fetch_error  out  1  sticky timeout flag. Constant 0 without FETCH_TIMEOUT_EN.
- op_code  out  6  IR[31:26].
- rs  out  5  IR[25:21].
- rt  out  5  IR[20:16].
- rd  out  5  IR[15:11].
- imm16  out  16  IR[15:0].
- target26  out  26  IR[25:0].
- pc  out  32  current PC.
- pc_plus4  out  32  pc + 4, combinational.

Behaviour:
- Reset (async, immediate):
  - pc = RESET_PC.
  - IR = 32'h0 (op_code 000000).
  - ir_valid, imem_req, fetch_busy and fetch_error = 0.
  - imem_addr = RESET_PC.
  - State = IDLE.
- States are encoded one-hot: IDLE, REQ, WAIT.
- IDLE:
  - On instruction_memory_read, load imem_addr with the next-PC value, clear ir_valid, go to REQ.
  - Otherwise stay in IDLE.
- REQ:
  - imem_req = 1 for exactly one cycle.
  - If imem_ready is high in the same cycle, latch imem_rdata into IR, set ir_valid, go to IDLE.
  - Otherwise go to WAIT.
- WAIT:
  - imem_req stays 1.
  - On imem_ready, latch the IR, set ir_valid, go to IDLE.
- Fetch latency: at least 2 clk edges from strobe to ir_valid (strobe edge, then ready edge). fetch_busy = (state != IDLE).
- Next-PC value: pc_update ? (mux_c ? branch_target : pc+4) : pc.
- pc_update handling:
  - Accepted only in IDLE; pc loads the next-PC value on that edge.
  - pc_update outside IDLE is ignored and the PC is unchanged.
- pc_update and instruction_memory_read in the same IDLE cycle: the PC updates and the fetch uses the updated value (imem_addr = new PC).
- instruction_memory_read in REQ/WAIT is ignored. No queuing.
- PC arithmetic:
  - 32-bit, wraps modulo 2^32 (32'hFFFF_FFFC + 4 = 0).
  - branch_target[1:0] is forced to 00 when loaded.
- IR and the decoded fields hold their value until the next successful fetch.
- The decoded fields are combinational slices of the IR.
- imem_ready outside REQ/WAIT is ignored.

Optional Feature:
- Macro: FETCH_TIMEOUT_EN.
- Defined:
  - A cycle counter runs in REQ/WAIT.
  - If imem_ready is not seen within TIMEOUT_CYCLES cycles of entering REQ, then: fetch_error sets (sticky until rst), IR loads 32'h0 (NOP/op 000000), ir_valid sets, state returns to IDLE.
  - The PC is unchanged.
  - A ready arriving on the same cycle as the timeout wins: data is latched and no error is flagged.
- Undefined: no counter; WAIT waits indefinitely; fetch_error is tied to 0.

Decomposition:
- Shared package cpu_pkg holds:
  - state encodings (FETCH_IDLE/REQ/WAIT);
  - field bit positions (OP_HI = 31, OP_LO = 26, etc.);
  - the NOP word constant;
  - the NPC_SEQ/NPC_BRANCH select constants;
  - the op_code constants shared with control_unit (6'b000100, 6'b001010, 6'b001000, 6'b001100, 6'b001110, 6'b000010, 6'b000000).
- One natural sub-module: pc_register (PC flop, +4 adder, next-PC mux, alignment forcing).
- The FSM and IR stay in the top module.

Test Plan:
- Reset → pc = 0, ir_valid = 0, imem_req = 0; release rst mid-cycle asynchronously → outputs stay at reset values until the first strobe.
- Strobe with imem_ready tied 1, imem_rdata = 32'h2108_0005 → imem_addr = 0, ir_valid 2 edges later, op_code = 001000, rs = 8, rt = 8, imm16 = 5.
- Ready delayed 3 cycles → fetch_busy high 4 cycles, imem_req held; a strobe during WAIT is ignored (no second request).
- pc_update with mux_c = 0 at pc = 32'hFFFF_FFFC → pc = 0; pc_update with mux_c = 1, branch_target = 32'h0000_0103 → pc = 32'h0000_0100.
- Simultaneous pc_update (mux_c = 1, target 32'h40) and strobe → imem_addr = 32'h40; pc_update asserted in WAIT → pc unchanged.
- With FETCH_TIMEOUT_EN and TIMEOUT_CYCLES = 16, ready never asserted → after 16 cycles fetch_error = 1, op_code = 000000, ir_valid = 1, FSM in IDLE; without the macro the FSM stays in WAIT.
